// File: rtl/pci_mon_cap_if.sv
// Monitor tap plus capture-record port for pci_mon_cap.
// The slave modport is the capture engine; every tap signal is an input to it.
interface pci_mon_cap_if #(
  parameter int C_DATA_WIDTH = 512,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int TUSER_WIDTH  = 183,
  parameter int HDR_WIDTH    = 128,
  parameter int TS_WIDTH     = 32
);
  localparam int REC_WIDTH = TS_WIDTH + 16 + HDR_WIDTH;

  logic                    s_axis_mon_tvalid;
  logic [C_DATA_WIDTH-1:0] s_axis_mon_tdata;
  logic [KEEP_WIDTH-1:0]   s_axis_mon_tkeep;
  logic                    s_axis_mon_tlast;
  logic [TUSER_WIDTH-1:0]  s_axis_mon_tuser;
  logic                    s_axis_mon_tready;

  logic                    m_cap_tvalid;
  logic [REC_WIDTH-1:0]    m_cap_tdata;
  logic                    m_cap_tready;

  modport master (
    output s_axis_mon_tvalid, s_axis_mon_tdata, s_axis_mon_tkeep,
           s_axis_mon_tlast, s_axis_mon_tuser, s_axis_mon_tready,
    output m_cap_tready,
    input  m_cap_tvalid, m_cap_tdata
  );

  modport slave (
    input  s_axis_mon_tvalid, s_axis_mon_tdata, s_axis_mon_tkeep,
           s_axis_mon_tlast, s_axis_mon_tuser, s_axis_mon_tready,
    input  m_cap_tready,
    output m_cap_tvalid, m_cap_tdata
  );
endinterface

// File: rtl/pci_mon_cap.sv
// Passive TLP capture engine for one PCIe AXI4-Stream monitor tap.
// Stores {start timestamp, beat count, header} per TLP in a FWFT record FIFO.
module pci_mon_cap #(
  parameter int C_DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH      = C_DATA_WIDTH / 32,
  parameter int TUSER_WIDTH     = 183,
  parameter int HDR_WIDTH       = 128,
  parameter int TS_WIDTH        = 32,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic              user_clk,
  input  logic              reset_n,
  pci_mon_cap_if.slave      mon,
  input  logic              cap_enable,
  input  logic              clr,
  output logic [31:0]       pkt_count,
  output logic [31:0]       drop_count,
  output logic              overflow
);
  localparam int REC_WIDTH = TS_WIDTH + 16 + HDR_WIDTH;
  localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam int L         = FIFO_DEPTH_LOG2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  localparam logic [L:0]          PTR_ONE = (L+1)'(1);
  localparam logic [TS_WIDTH-1:0] TS_ONE  = TS_WIDTH'(1);

  logic [0:0]           state;
  logic [TS_WIDTH-1:0]  ts;
  logic [TS_WIDTH-1:0]  ts_lat;
  logic [HDR_WIDTH-1:0] hdr;
  logic [15:0]          beats;
  logic                 cap_act;

  logic                 hs;
  logic                 sop;
  logic                 done;
  logic [TS_WIDTH-1:0]  rec_ts;
  logic [HDR_WIDTH-1:0] rec_hdr;
  logic [15:0]          rec_beats;
  logic                 rec_act;

  logic [REC_WIDTH-1:0] mem [DEPTH];
  logic [L:0]           wr_ptr;
  logic [L:0]           rd_ptr;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 unused_tap;

  assign hs   = mon.s_axis_mon_tvalid & mon.s_axis_mon_tready;
  assign sop  = hs & (state == ST_IDLE);
  assign done = hs & mon.s_axis_mon_tlast;

  assign unused_tap = ^{mon.s_axis_mon_tkeep, mon.s_axis_mon_tuser, mon.s_axis_mon_tdata};

  // Record fields as they will look after this beat, so a completing beat
  // (including a single-beat TLP) can be pushed at its own handshake edge.
  always_comb begin
    rec_ts    = ts_lat;
    rec_hdr   = hdr;
    rec_beats = (beats == 16'hFFFF) ? beats : beats + 16'd1;
    rec_act   = cap_act;
    if (sop) begin
      rec_ts    = ts;
      rec_hdr   = mon.s_axis_mon_tdata[HDR_WIDTH-1:0];
      rec_beats = 16'd1;
      rec_act   = cap_enable;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[L] != rd_ptr[L]) && (wr_ptr[L-1:0] == rd_ptr[L-1:0]);
  assign pop        = ~fifo_empty & mon.m_cap_tready & ~clr;
  assign push       = done & rec_act & ~clr & (~fifo_full | pop);
  assign drop       = done & rec_act & ~clr & fifo_full & ~pop;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_ONE;
    end
  end

  // Boundary tracking ignores clr and enable so SOP detection never slips.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (hs) begin
      state <= mon.s_axis_mon_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr     <= '0;
      ts_lat  <= '0;
      beats   <= '0;
      cap_act <= 1'b0;
    end else begin
      if (hs) begin
        hdr    <= rec_hdr;
        ts_lat <= rec_ts;
        beats  <= rec_beats;
      end
      if (clr) begin
        cap_act <= 1'b0;
      end else if (sop) begin
        cap_act <= cap_enable;
      end
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge user_clk) begin
    if (push) mem[wr_ptr[L-1:0]] <= {rec_ts, rec_beats, rec_hdr};
  end

  assign mon.m_cap_tvalid = ~fifo_empty;
  assign mon.m_cap_tdata  = fifo_empty ? '0 : mem[rd_ptr[L-1:0]];

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      pkt_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (done && rec_act && pkt_count != 32'hFFFF_FFFF) pkt_count <= pkt_count + 32'd1;
      if (drop) begin
        if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
        overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pci_mon_cap.sv
// Self-checking bench for pci_mon_cap: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pci_mon_cap;
  localparam int DW    = 512;
  localparam int KW    = DW / 32;
  localparam int UW    = 183;
  localparam int HW    = 128;
  localparam int TW    = 32;
  localparam int DEPTH = 16;
  localparam int RW    = TW + 16 + HW;

  logic        user_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cap_enable;
  logic        clr;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic        overflow;

  pci_mon_cap_if #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(UW),
                   .HDR_WIDTH(HW), .TS_WIDTH(TW)) mon_bus ();

  pci_mon_cap #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(UW),
                .HDR_WIDTH(HW), .TS_WIDTH(TW), .FIFO_DEPTH_LOG2(4)) dut (
    .user_clk   (user_clk),
    .reset_n    (reset_n),
    .mon        (mon_bus),
    .cap_enable (cap_enable),
    .clr        (clr),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    int          nbeats;
    bit          en_sop;
    bit          en_rest;
    int          stall;
    logic [HW-1:0] hdr;
    bit          exp_rec;
    logic [15:0] exp_beats;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the reader should see, kept as a plain queue.
  logic [RW-1:0] exp_q[$];
  logic [31:0]   m_pkt, m_drop;
  bit            m_ovf, m_in_pkt, m_act;
  logic [HW-1:0] m_hdr;
  logic [TW-1:0] m_ts, m_tsnow;
  logic [15:0]   m_beats;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pkt = 0; m_drop = 0; m_ovf = 0; m_in_pkt = 0; m_act = 0;
    m_hdr = '0; m_ts = '0; m_tsnow = '0; m_beats = '0;
  endtask

  task automatic model_edge();
    bit hs, done, full, pop;
    hs   = mon_bus.s_axis_mon_tvalid & mon_bus.s_axis_mon_tready;
    done = 0;
    full = exp_q.size() >= DEPTH;
    pop  = exp_q.size() > 0 && mon_bus.m_cap_tready;
    if (hs) begin
      if (!m_in_pkt) begin
        m_act = cap_enable; m_hdr = mon_bus.s_axis_mon_tdata[HW-1:0];
        m_ts = m_tsnow; m_beats = 16'd1;
      end else if (m_beats != 16'hFFFF) begin
        m_beats++;
      end
      done     = mon_bus.s_axis_mon_tlast;
      m_in_pkt = !mon_bus.s_axis_mon_tlast;
    end
    if (clr) begin
      exp_q.delete(); m_pkt = 0; m_drop = 0; m_ovf = 0; m_act = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (done && m_act) begin
        if (m_pkt != 32'hFFFF_FFFF) m_pkt++;
        if (!full || pop) exp_q.push_back({m_ts, m_beats, m_hdr});
        else begin
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
          m_ovf = 1;
        end
      end
    end
    m_tsnow++;
  endtask

  task automatic check_all();
    check("cap_tvalid", mon_bus.m_cap_tvalid, exp_q.size() > 0);
    check("cap_tdata", mon_bus.m_cap_tdata, exp_q.size() > 0 ? exp_q[0] : '0);
    check("pkt_count", pkt_count, m_pkt);
    check("drop_count", drop_count, m_drop);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    @(posedge user_clk);
    if (reset_n) model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic applyStimulus(input int nbeats, input bit en_sop, input bit en_rest,
                               input int stall, input logic [HW-1:0] hdr, input bit pop_on_last);
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 1) begin
        for (int s = 0; s < stall; s++) begin
          mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tready = 0;
          mon_bus.s_axis_mon_tlast = 0; mon_bus.s_axis_mon_tdata = rand_data();
          tick();
        end
      end
      d = rand_data();
      if (b == 0) d[HW-1:0] = hdr;
      mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tready = 1;
      mon_bus.s_axis_mon_tlast  = (b == nbeats - 1);
      mon_bus.s_axis_mon_tdata  = d;
      cap_enable = (b == 0) ? en_sop : en_rest;
      if (pop_on_last && b == nbeats - 1) mon_bus.m_cap_tready = 1;
      tick();
    end
    mon_bus.s_axis_mon_tvalid = 0; mon_bus.s_axis_mon_tlast = 0;
    if (pop_on_last) mon_bus.m_cap_tready = 0;
  endtask

  task automatic pop_one();
    mon_bus.m_cap_tready = 1;
    tick();
    mon_bus.m_cap_tready = 0;
  endtask

  vec_t          vecs[7];
  logic [HW-1:0] hdrs[18];
  logic [31:0]   pkt_before;
  int            n;

  initial begin
    mon_bus.s_axis_mon_tvalid = 0; mon_bus.s_axis_mon_tdata = '0;
    mon_bus.s_axis_mon_tkeep = '1; mon_bus.s_axis_mon_tlast = 0;
    mon_bus.s_axis_mon_tuser = '0; mon_bus.s_axis_mon_tready = 1;
    mon_bus.m_cap_tready = 0; cap_enable = 0; clr = 0;
    model_reset();

    vecs[0] = '{1, 1, 1, 0, {4{32'h1111_0001}}, 1, 16'd1};
    vecs[1] = '{3, 1, 1, 2, {4{32'h2222_0002}}, 1, 16'd3};
    vecs[2] = '{3, 1, 0, 0, {4{32'h3333_0003}}, 1, 16'd3};
    vecs[3] = '{3, 0, 1, 1, {4{32'h4444_0004}}, 0, 16'd0};
    vecs[4] = '{2, 1, 1, 0, {4{32'h5555_0005}}, 1, 16'd2};
    vecs[5] = '{5, 0, 0, 0, {4{32'h6666_0006}}, 0, 16'd0};
    vecs[6] = '{4, 1, 1, 3, {4{32'h7777_0007}}, 1, 16'd4};

    #20;
    check_all();
    reset_n = 1;

    // Single-beat TLP whose SOP lands on ts = 0x10.
    for (int i = 0; i < 16; i++) tick();
    mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tlast = 1;
    mon_bus.s_axis_mon_tdata = rand_data();
    mon_bus.s_axis_mon_tdata[HW-1:0] = {4{32'hA5A5_A5A5}};
    cap_enable = 1;
    tick();
    mon_bus.s_axis_mon_tvalid = 0; mon_bus.s_axis_mon_tlast = 0;
    check("single_rec", mon_bus.m_cap_tdata, {32'h10, 16'h0001, {4{32'hA5A5_A5A5}}});
    check("single_pkt", pkt_count, 32'd1);
    pop_one();

    for (int i = 0; i < 7; i++) begin
      pkt_before = pkt_count;
      applyStimulus(vecs[i].nbeats, vecs[i].en_sop, vecs[i].en_rest, vecs[i].stall, vecs[i].hdr, 0);
      check("vec_valid", mon_bus.m_cap_tvalid, vecs[i].exp_rec);
      check("vec_pkt", pkt_count, pkt_before + 32'(vecs[i].exp_rec));
      if (mon_bus.m_cap_tvalid) begin
        check("vec_beats", mon_bus.m_cap_tdata[HW+15:HW], vecs[i].exp_beats);
        check("vec_hdr", mon_bus.m_cap_tdata[HW-1:0], vecs[i].hdr);
        pop_one();
      end
    end

    // Fill past depth with the reader stalled, then complete one TLP during a pop.
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 18; i++) hdrs[i] = {$urandom, $urandom, $urandom, 32'(i)};
    for (int i = 0; i < 17; i++) applyStimulus(1 + (i % 2), 1, 1, 0, hdrs[i], 0);
    check("ovf_drop", drop_count, 32'd1);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_pkt", pkt_count, 32'd17);
    applyStimulus(2, 1, 1, 0, hdrs[17], 1);
    check("full_pop_drop", drop_count, 32'd1);
    check("full_pop_pkt", pkt_count, 32'd18);
    n = 0;
    while (mon_bus.m_cap_tvalid && n < 40) begin
      check("drain_order", mon_bus.m_cap_tdata[HW-1:0], (n < 15) ? hdrs[n+1] : hdrs[17]);
      pop_one();
      n++;
    end
    check("drain_count", 32'(n), 32'd16);

    // clr mid-packet with three records queued.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, hdrs[i], 0);
    mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tlast = 0;
    mon_bus.s_axis_mon_tdata = rand_data(); cap_enable = 1;
    tick();
    mon_bus.s_axis_mon_tvalid = 0; clr = 1;
    tick();
    clr = 0; mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tlast = 1;
    tick();
    mon_bus.s_axis_mon_tvalid = 0; mon_bus.s_axis_mon_tlast = 0;
    check("clr_valid", mon_bus.m_cap_tvalid, 1'b0);
    check("clr_pkt", pkt_count, 32'd0);
    check("clr_drop", drop_count, 32'd0);
    check("clr_ovf", overflow, 1'b0);
    applyStimulus(2, 1, 1, 0, hdrs[5], 0);
    check("after_clr_valid", mon_bus.m_cap_tvalid, 1'b1);
    check("after_clr_hdr", mon_bus.m_cap_tdata[HW-1:0], hdrs[5]);
    pop_one();

    // Randomized traffic, alternating reader-starved and reader-eager phases.
    for (int i = 0; i < 3000; i++) begin
      mon_bus.s_axis_mon_tvalid = ($urandom_range(99) < 70);
      mon_bus.s_axis_mon_tready = ($urandom_range(99) < 75);
      mon_bus.s_axis_mon_tlast  = ($urandom_range(99) < 30);
      mon_bus.s_axis_mon_tdata  = rand_data();
      cap_enable = ($urandom_range(99) < 80);
      mon_bus.m_cap_tready = ($urandom_range(99) < (((i / 300) % 2 == 1) ? 10 : 60));
      clr = ($urandom_range(999) < 10);
      tick();
    end
    clr = 0; mon_bus.s_axis_mon_tready = 1; mon_bus.m_cap_tready = 0;
    applyStimulus(1, 1, 1, 0, hdrs[0], 0);

    // Asynchronous reset in the middle of a packet.
    mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tlast = 0; cap_enable = 1;
    tick();
    #2 reset_n = 0;
    #1;
    model_reset();
    check("rst_valid", mon_bus.m_cap_tvalid, 1'b0);
    check("rst_tdata", mon_bus.m_cap_tdata, '0);
    check("rst_pkt", pkt_count, 32'd0);
    check_all();
    mon_bus.s_axis_mon_tvalid = 0;
    @(negedge user_clk);
    reset_n = 1;
    mon_bus.s_axis_mon_tvalid = 1; mon_bus.s_axis_mon_tlast = 1;
    mon_bus.s_axis_mon_tdata[HW-1:0] = hdrs[9];
    tick();
    mon_bus.s_axis_mon_tvalid = 0; mon_bus.s_axis_mon_tlast = 0;
    check("post_rst_beats", mon_bus.m_cap_tdata[HW+15:HW], 16'd1);
    check("post_rst_ts", mon_bus.m_cap_tdata[RW-1:HW+16], 32'd0);
    check("post_rst_hdr", mon_bus.m_cap_tdata[HW-1:0], hdrs[9]);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
